// File: rtl/data_reg_bank_pkg.sv
// Shared definitions for the data register bank and its stream sequencer.
package data_reg_bank_pkg;

  typedef logic [1:0] seq_state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Entry i of a packed N*W bus lives at bits [i*W +: W].
  function automatic int unsigned slice_lsb(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/reg_bank_streamer.sv
// Sequencer that walks the bank in ascending address order and presents each
// valid entry on a valid/ready stream, holding the word until it is accepted.
module reg_bank_streamer
  import data_reg_bank_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int W  = 32,
  localparam int AW = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic            stream_ready_i,
  input  logic [N*W-1:0]  entries_i,
  input  logic [N-1:0]    valid_i,
  output logic [W-1:0]    stream_data_o,
  output logic [AW-1:0]   stream_addr_o,
  output logic            stream_valid_o,
  output logic            busy_o,
  output logic            done_o
);

  seq_state_t    state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [W-1:0]  data_q, data_d;
  logic [AW-1:0] addr_q, addr_d;

  logic [W-1:0]  cur_entry;
  logic          cur_valid;
  logic          at_last;

  // NOTE: every combinational output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cur_entry = '0;
    cur_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (ptr_q == AW'(i)) begin
        cur_entry = entries_i[slice_lsb(i, W) +: W];
        cur_valid = valid_i[i];
      end
    end
  end

  assign at_last = (ptr_q == AW'(N - 1));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    addr_d  = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_SCAN;
          ptr_d   = '0;
        end
      end
      ST_SCAN: begin
        if (cur_valid) begin
          data_d  = cur_entry;
          addr_d  = ptr_q;
          state_d = ST_SEND;
        end else if (at_last) begin
          state_d = ST_DONE;
        end else begin
          ptr_d = ptr_q + AW'(1);
        end
      end
      ST_SEND: begin
        // The presented word lives in data_q/addr_q, so bank writes cannot disturb it.
        if (stream_ready_i) begin
          if (at_last) begin
            state_d = ST_DONE;
          end else begin
            ptr_d   = ptr_q + AW'(1);
            state_d = ST_SCAN;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
    end
  end

  assign stream_data_o  = data_q;
  assign stream_addr_o  = addr_q;
  assign stream_valid_o = (state_q == ST_SEND);
  assign busy_o         = (state_q != ST_IDLE);
  assign done_o         = (state_q == ST_DONE);

endmodule

// File: rtl/data_reg_bank_stream.sv
// N-entry data register bank with per-entry valid flags, single/snapshot
// loading and an in-order stream of the valid entries.
module data_reg_bank_stream
  import data_reg_bank_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int W  = 32,
  localparam int AW = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N*W-1:0]  in_all,
  input  logic [W-1:0]    data_in,
  input  logic [AW-1:0]   address,
  input  logic            write_address,
  input  logic            write_all,
  input  logic            clear,
  input  logic            start,
  input  logic            stream_ready,
  output logic [N*W-1:0]  out_all,
  output logic [N-1:0]    valid_mask,
  output logic [W-1:0]    stream_data,
  output logic [AW-1:0]   stream_addr,
  output logic            stream_valid,
  output logic            busy,
  output logic            done
);

  logic [W-1:0] entry_q [N];
  logic [W-1:0] entry_d [N];
  logic [N-1:0] valid_q, valid_d;

  // Priority clear > write_address > write_all; an out-of-range address matches no entry.
  always_comb begin
    entry_d = entry_q;
    valid_d = valid_q;
    if (clear) begin
      for (int i = 0; i < N; i++) entry_d[i] = '0;
      valid_d = '0;
    end else if (write_address) begin
      for (int i = 0; i < N; i++) begin
        if (address == AW'(i)) begin
          entry_d[i] = data_in;
          valid_d[i] = 1'b1;
        end
      end
    end else if (write_all) begin
      for (int i = 0; i < N; i++) entry_d[i] = in_all[slice_lsb(i, W) +: W];
      valid_d = '1;
    end
  end

  // NOTE: the storage array is reset on purpose; out_all must read zero straight after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) entry_q[i] <= '0;
      valid_q <= '0;
    end else begin
      entry_q <= entry_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    out_all = '0;
    for (int i = 0; i < N; i++) out_all[slice_lsb(i, W) +: W] = entry_q[i];
  end

  assign valid_mask = valid_q;

  reg_bank_streamer #(
    .N (N),
    .W (W)
  ) u_streamer (
    .clk            (clk),
    .reset          (reset),
    .start_i        (start),
    .stream_ready_i (stream_ready),
    .entries_i      (out_all),
    .valid_i        (valid_q),
    .stream_data_o  (stream_data),
    .stream_addr_o  (stream_addr),
    .stream_valid_o (stream_valid),
    .busy_o         (busy),
    .done_o         (done)
  );

endmodule

// File: tb/tb_data_reg_bank_stream.sv
// Bench for data_reg_bank_stream: directed tests on the default build, random
// bank traffic and back-pressured streams on an N=6, W=8 build.
module tb_data_reg_bank_stream;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Default build: N=4, W=32
  logic [127:0] a_in_all, a_out_all;
  logic [31:0]  a_din, a_sdata;
  logic [1:0]   a_addr, a_saddr;
  logic         a_wa, a_wall, a_clear, a_start, a_ready;
  logic [3:0]   a_valid_mask;
  logic         a_svalid, a_busy, a_done;

  // Second build: N=6, W=8
  logic [47:0]  b_in_all, b_out_all;
  logic [7:0]   b_din, b_sdata;
  logic [2:0]   b_addr, b_saddr;
  logic         b_wa, b_wall, b_clear, b_start, b_ready;
  logic [5:0]   b_valid_mask;
  logic         b_svalid, b_busy, b_done;

  data_reg_bank_stream dut_a (
    .clk(clk), .reset(reset), .in_all(a_in_all), .data_in(a_din), .address(a_addr),
    .write_address(a_wa), .write_all(a_wall), .clear(a_clear), .start(a_start),
    .stream_ready(a_ready), .out_all(a_out_all), .valid_mask(a_valid_mask),
    .stream_data(a_sdata), .stream_addr(a_saddr), .stream_valid(a_svalid),
    .busy(a_busy), .done(a_done)
  );

  data_reg_bank_stream #(.N(6), .W(8)) dut_b (
    .clk(clk), .reset(reset), .in_all(b_in_all), .data_in(b_din), .address(b_addr),
    .write_address(b_wa), .write_all(b_wall), .clear(b_clear), .start(b_start),
    .stream_ready(b_ready), .out_all(b_out_all), .valid_mask(b_valid_mask),
    .stream_data(b_sdata), .stream_addr(b_saddr), .stream_valid(b_svalid),
    .busy(b_busy), .done(b_done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model of the N=6 bank
  logic [7:0] m_entry [6];
  logic [5:0] m_valid;

  function automatic logic [47:0] m_pack();
    logic [47:0] p;
    for (int i = 0; i < 6; i++) p[i*8 +: 8] = m_entry[i];
    return p;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 6; i++) m_entry[i] = 8'h00;
    m_valid = 6'h00;
  endtask

  task automatic b_write(input logic clr, input logic wa, input logic wall,
                         input logic [2:0] addr, input logic [7:0] din, input logic [47:0] all);
    b_clear = clr; b_wa = wa; b_wall = wall; b_addr = addr; b_din = din; b_in_all = all;
    step();
    if (clr) m_reset();
    else if (wa) begin
      if (addr < 6) begin
        m_entry[addr] = din;
        m_valid[addr] = 1'b1;
      end
    end else if (wall) begin
      for (int i = 0; i < 6; i++) m_entry[i] = all[i*8 +: 8];
      m_valid = 6'h3f;
    end
    b_clear = 1'b0; b_wa = 1'b0; b_wall = 1'b0;
    check("b_out_all", b_out_all, m_pack());
    check("b_valid_mask", b_valid_mask, m_valid);
  endtask

  task automatic b_rand_write();
    b_write(($urandom_range(7) == 0), 1'($urandom_range(1)), ($urandom_range(3) == 0),
            3'($urandom_range(7)), 8'($urandom), 48'({$urandom(), $urandom()}));
  endtask

  // One stream pass with random back-pressure; expected words are the valid entries in order.
  task automatic b_pass();
    int         exp_addr [$];
    logic [7:0] exp_data [$];
    int n_exp, n_got, dones, cyc, ea;
    logic [7:0] ed;
    for (int i = 0; i < 6; i++) begin
      if (m_valid[i]) begin
        exp_addr.push_back(i);
        exp_data.push_back(m_entry[i]);
      end
    end
    n_exp = exp_addr.size();
    n_got = 0; dones = 0; cyc = 0;
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    while (cyc < 300) begin
      if (b_done) dones++;
      if (!b_busy) break;
      b_ready = 1'($urandom_range(1));
      if (b_svalid && b_ready) begin
        if (exp_addr.size() == 0) check("b_extra_word", 1'b1, 1'b0);
        else begin
          ea = exp_addr.pop_front();
          ed = exp_data.pop_front();
          check("b_stream_addr", b_saddr, ea);
          check("b_stream_data", b_sdata, ed);
        end
        n_got++;
      end
      step();
      cyc++;
    end
    b_ready = 1'b0;
    check("b_pass_ended", b_busy, 1'b0);
    check("b_word_count", n_got, n_exp);
    check("b_done_pulses", dones, 1);
  endtask

  initial begin
    int k, dones, done_at, widx, sv_seen;
    int         ea_list [2];
    logic [31:0] ed_list [2];

    reset = 1'b1;
    {a_in_all, a_din, a_addr, a_wa, a_wall, a_clear, a_start, a_ready} = '0;
    {b_in_all, b_din, b_addr, b_wa, b_wall, b_clear, b_start, b_ready} = '0;
    step();
    step();
    check("a_reset_out_all", a_out_all, 128'h0);
    check("a_reset_valid", a_valid_mask, 4'h0);
    check("a_reset_stream", {a_svalid, a_busy, a_done, a_sdata, a_saddr}, '0);
    check("b_reset_out_all", b_out_all, 48'h0);
    reset = 1'b0;
    step();

    // Snapshot load, then asynchronous reset in the middle of a cycle
    a_in_all = {32'h44, 32'h33, 32'h22, 32'h11};
    a_wall = 1'b1;
    step();
    a_wall = 1'b0;
    check("a_write_all", a_out_all, {32'h44, 32'h33, 32'h22, 32'h11});
    check("a_write_all_valid", a_valid_mask, 4'hf);
    reset = 1'b1;
    #1;
    check("a_async_reset_out_all", a_out_all, 128'h0);
    check("a_async_reset_valid", a_valid_mask, 4'h0);
    reset = 1'b0;
    step();

    // write_address beats write_all
    a_wall = 1'b1;
    step();
    a_in_all = {4{32'h55}};
    a_wa = 1'b1; a_addr = 2'd2; a_din = 32'hAA;
    step();
    a_wa = 1'b0; a_wall = 1'b0;
    check("a_priority_wa", a_out_all, {32'h44, 32'hAA, 32'h22, 32'h11});
    check("a_priority_valid", a_valid_mask, 4'hf);

    // clear beats write_address
    a_clear = 1'b1; a_wa = 1'b1; a_addr = 2'd0; a_din = 32'h12;
    step();
    a_clear = 1'b0; a_wa = 1'b0;
    check("a_clear_out_all", a_out_all, 128'h0);
    check("a_clear_valid", a_valid_mask, 4'h0);

    // Entries 1 and 3 valid, ready tied high
    a_wa = 1'b1; a_addr = 2'd1; a_din = 32'h22;
    step();
    a_addr = 2'd3; a_din = 32'h44;
    step();
    a_wa = 1'b0;
    check("a_sparse_valid", a_valid_mask, 4'b1010);
    ea_list[0] = 1; ed_list[0] = 32'h22;
    ea_list[1] = 3; ed_list[1] = 32'h44;
    a_ready = 1'b1;
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    k = 1; dones = 0; done_at = -1; widx = 0;
    while (k <= 40) begin
      if (a_svalid) begin
        if (widx < 2) begin
          check("a_stream_addr", a_saddr, ea_list[widx]);
          check("a_stream_data", a_sdata, ed_list[widx]);
        end
        widx++;
      end
      if (a_done) begin dones++; done_at = k; end
      if (!a_busy) break;
      step();
      k++;
    end
    check("a_sparse_words", widx, 2);
    check("a_sparse_done_pulses", dones, 1);
    check("a_sparse_done_time", done_at, 4 + 2 + 1);
    check("a_sparse_busy_low", a_busy, 1'b0);

    // Back-pressure: presented word stays put while the bank is rewritten
    a_ready = 1'b0;
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    for (int w = 0; w < 20 && !a_svalid; w++) step();
    check("a_bp_present", a_svalid, 1'b1);
    check("a_bp_addr", a_saddr, 2'd1);
    for (int j = 0; j < 5; j++) begin
      a_wa = 1'b1;
      a_addr = (j == 4) ? 2'd3 : 2'd1;
      a_din  = (j == 4) ? 32'h77 : 32'h99;
      step();
      check("a_bp_hold_data", a_sdata, 32'h22);
      check("a_bp_hold_valid", a_svalid, 1'b1);
    end
    a_wa = 1'b0;
    check("a_bp_bank_updated", a_out_all, {32'h77, 32'h0, 32'h99, 32'h0});
    a_ready = 1'b1;
    step();
    for (int w = 0; w < 20 && !a_svalid; w++) step();
    check("a_bp_next_addr", a_saddr, 2'd3);
    check("a_bp_next_data", a_sdata, 32'h77);
    step();
    check("a_bp_done", a_done, 1'b1);
    step();
    check("a_bp_idle", a_busy, 1'b0);

    // Empty pass, with a start request while busy that must be ignored
    a_clear = 1'b1;
    step();
    a_clear = 1'b0;
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    k = 1; dones = 0; done_at = -1; sv_seen = 0;
    while (k <= 40) begin
      if (a_svalid) sv_seen++;
      if (a_done) begin dones++; done_at = k; end
      if (!a_busy) break;
      a_start = (k == 2);
      step();
      a_start = 1'b0;
      k++;
    end
    for (int j = 0; j < 3; j++) begin
      step();
      if (a_done) dones++;
    end
    check("a_empty_no_valid", sv_seen, 0);
    check("a_empty_done_time", done_at, 4 + 1);
    check("a_empty_done_pulses", dones, 1);

    // Reset in the middle of a stream
    a_wa = 1'b1; a_addr = 2'd0; a_din = 32'h5;
    step();
    a_wa = 1'b0; a_ready = 1'b0; a_start = 1'b1;
    step();
    a_start = 1'b0;
    for (int w = 0; w < 20 && !a_svalid; w++) step();
    check("a_midstream_present", a_svalid, 1'b1);
    reset = 1'b1;
    #1;
    check("a_midstream_reset", {a_svalid, a_busy, a_done, a_sdata, a_saddr}, '0);
    check("a_midstream_reset_bank", a_out_all, 128'h0);
    reset = 1'b0;
    step();
    check("a_after_reset_done", a_done, 1'b0);

    // N=6 build
    m_reset();
    b_write(1'b0, 1'b1, 1'b0, 3'd7, 8'h5A, 48'h0);
    b_write(1'b0, 1'b1, 1'b0, 3'd6, 8'hA5, 48'h0);
    b_write(1'b0, 1'b0, 1'b1, 3'd0, 8'h00, 48'({$urandom(), $urandom()}));
    b_pass();
    for (int r = 0; r < 12; r++) begin
      for (int j = 0; j < 6; j++) b_rand_write();
      b_pass();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
